// File: rtl/music_defs_pkg.sv
// Shared definitions for the music player tone path: code widths, state encoding
// and note-code classification.
package music_defs_pkg;

  localparam int unsigned CODE_W   = 5;
  localparam int unsigned PERIOD_W = 17;

  localparam logic [CODE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [CODE_W-1:0] NOTE_MAX  = 5'd21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    TONE = 2'd2
  } state_e;

  // Codes 1..21 are playable notes; 0 is a rest and 22..31 are treated as rests.
  function automatic logic is_note(input logic [CODE_W-1:0] code);
    return (code != NOTE_REST) && (code <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Note code to half-period (in 50 MHz cycles) lookup; purely combinational.
module note_period_lut
  import music_defs_pkg::*;
(
  input  logic [CODE_W-1:0]   code,
  output logic [PERIOD_W-1:0] half,
  output logic                valid
);

  always_comb begin
    half  = '0;
    valid = is_note(code);
    case (code)
      5'd1:    half = 17'd95555;
      5'd2:    half = 17'd85132;
      5'd3:    half = 17'd75844;
      5'd4:    half = 17'd71586;
      5'd5:    half = 17'd63776;
      5'd6:    half = 17'd56818;
      5'd7:    half = 17'd50620;
      5'd8:    half = 17'd47778;
      5'd9:    half = 17'd42566;
      5'd10:   half = 17'd37922;
      5'd11:   half = 17'd35793;
      5'd12:   half = 17'd31888;
      5'd13:   half = 17'd28409;
      5'd14:   half = 17'd25310;
      5'd15:   half = 17'd23889;
      5'd16:   half = 17'd21283;
      5'd17:   half = 17'd18961;
      5'd18:   half = 17'd17897;
      5'd19:   half = 17'd15944;
      5'd20:   half = 17'd14205;
      5'd21:   half = 17'd12655;
      default: half = '0;
    endcase
  end

endmodule

// File: rtl/note_tone_gen.sv
// Turns score note codes into a buzzer square wave, one note per clk_4 tick, with a
// short silent gap between repeated notes.
module note_tone_gen
  import music_defs_pkg::state_e, music_defs_pkg::IDLE, music_defs_pkg::GAP,
         music_defs_pkg::TONE, music_defs_pkg::PERIOD_W;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned GAP_CYCLES = 250_000,
  parameter int unsigned CODE_W     = music_defs_pkg::CODE_W
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clk_4,
  input  logic [CODE_W-1:0] note_code,
  output logic              beep,
  output logic              note_active,
  output logic [CODE_W-1:0] cur_note
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // The period table is built for one clock rate and one code width.
  if (CLK_HZ != 50_000_000 || CODE_W != music_defs_pkg::CODE_W) begin : g_cfg_check
    $error("note_tone_gen: period table requires CLK_HZ=50000000 and CODE_W=5");
  end

  state_e              state_q,       state_d;
  logic [2:0]          sync_q,        sync_d;
  logic [PERIOD_W-1:0] half_cnt_q,    half_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q,     gap_cnt_d;
  logic                beep_q,        beep_d;
  logic                note_active_q, note_active_d;
  logic [CODE_W-1:0]   cur_note_q,    cur_note_d;

  logic                tick_c;
  logic [CODE_W-1:0]   lut_code_c;
  logic [PERIOD_W-1:0] lut_half_c;
  logic                lut_valid_c;

  assign tick_c = sync_q[1] & ~sync_q[2];

  // On a tick the LUT classifies the incoming code; otherwise it times the sounding note.
  assign lut_code_c = tick_c ? note_code : cur_note_q;

  note_period_lut u_lut (
    .code  (lut_code_c),
    .half  (lut_half_c),
    .valid (lut_valid_c)
  );

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[1:0], clk_4};
    half_cnt_d = half_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    beep_d     = beep_q;
    cur_note_d = cur_note_q;

    if (!en) begin
      state_d    = IDLE;
      half_cnt_d = '0;
      gap_cnt_d  = '0;
      beep_d     = 1'b0;
      cur_note_d = '0;
    end else if (tick_c) begin
      half_cnt_d = '0;
      gap_cnt_d  = '0;
      beep_d     = 1'b0;
      if (!lut_valid_c) begin
        state_d    = IDLE;
        cur_note_d = '0;
      end else if (note_code != cur_note_q) begin
        state_d    = TONE;
        cur_note_d = note_code;
      end else if (GAP_CYCLES > 0) begin
        state_d = GAP;
      end else begin
        state_d = TONE;
      end
    end else begin
      case (state_q)
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d    = TONE;
            gap_cnt_d  = '0;
            half_cnt_d = '0;
            beep_d     = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        TONE: begin
          if (half_cnt_q == lut_half_c - PERIOD_W'(1)) begin
            half_cnt_d = '0;
            beep_d     = ~beep_q;
          end else begin
            half_cnt_d = half_cnt_q + PERIOD_W'(1);
          end
        end
        default: ;
      endcase
    end

    note_active_d = (state_d == TONE);
  end

  always_ff @(posedge in_clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      sync_q        <= 3'b111;
      half_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      beep_q        <= 1'b0;
      note_active_q <= 1'b0;
      cur_note_q    <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      half_cnt_q    <= half_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      beep_q        <= beep_d;
      note_active_q <= note_active_d;
      cur_note_q    <= cur_note_d;
    end
  end

  assign beep        = beep_q;
  assign note_active = note_active_q;
  assign cur_note    = cur_note_q;

endmodule
